// File: rtl/smem_pkg.sv
// Shared types and constants for the SMEM output writer.
// Line width, writer FSM encoding and the trailer-line format.
package smem_pkg;

  localparam int LINE_W = 512;

  typedef enum logic [1:0] {
    OW_IDLE,
    OW_STREAM,
    OW_DRAIN,
    OW_TRAILER
  } ow_state_e;

  // Trailer: line count zero-extended into the low bits of a line.
  function automatic logic [LINE_W-1:0] trailer_line(
    input logic [63:0] cnt
  );
    return LINE_W'(cnt);
  endfunction

endpackage

// File: rtl/smem_output_writer_if.sv
// Upstream result stream plus host write channel of the output writer.
// master: writer side (permit, wr_*); slave: upstream/host side.
interface smem_output_writer_if
  import smem_pkg::*;
#(
  parameter int ADDR_W = 32
) ();

  logic              output_request;
  logic              output_permit;
  logic [LINE_W-1:0] output_data;
  logic              output_valid;
  logic              output_finish;

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [LINE_W-1:0] wr_data;

  modport master (
    input  output_request,
    input  output_data,
    input  output_valid,
    input  output_finish,
    input  wr_ready,
    output output_permit,
    output wr_valid,
    output wr_addr,
    output wr_data
  );

  modport slave (
    output output_request,
    output output_data,
    output output_valid,
    output output_finish,
    output wr_ready,
    input  output_permit,
    input  wr_valid,
    input  wr_addr,
    input  wr_data
  );

endinterface

// File: rtl/smem_line_fifo.sv
// Registered synchronous line FIFO with full/empty/free-count.
// Ports: clk, rst_n, push_i/data_i, pop_i/data_o, full_o, empty_o, free_o.
module smem_line_fifo #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 512,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      free_o
);

  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;
  logic [AW:0]      count;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign count   = wptr_q - rptr_q;
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (count == (AW+1)'(DEPTH));
  assign free_o  = (AW+1)'(DEPTH) - count;
  assign data_o  = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + 1'b1;
      if (pop_i)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage is not reset; the reader gates data_o while empty.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/smem_output_writer.sv
// Collects SMEM result lines, writes them to host memory, then a trailer.
// Ports: clk, reset_n, enable, out_base, stall/stall_req, bus, batch status.
module smem_output_writer
  import smem_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int STALL_SLACK = 4,
  parameter int ADDR_W      = 32,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [ADDR_W-1:0]     out_base,
  input  logic                  stall,
  output logic                  stall_req,
  smem_output_writer_if.master  bus,
  output logic                  batch_done,
  output logic [CNT_W-1:0]      line_count,
  output logic                  overflow_err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ow_state_e         state_q;
  logic              permit_q;
  logic              stall_req_q;
  logic              done_q;
  logic              ovf_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] idx_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              full;
  logic              empty;
  logic [PW:0]       free;
  logic [LINE_W-1:0] head;

  logic              in_data;
  logic              head_vld;
  logic              push_req;
  logic              push;
  logic              pop;
  logic              drop;
  logic              fin;
  logic              stream_nxt;
  logic [PW:0]       free_nxt;

  assign in_data  = (state_q == OW_STREAM) ||
                    (state_q == OW_DRAIN);
  assign head_vld = in_data && !empty;
  assign push_req = (state_q == OW_STREAM) &&
                    bus.output_valid && !stall;
  assign pop      = head_vld && bus.wr_ready;
  // A full FIFO still takes a line when a pop frees a slot.
  assign drop     = push_req && full && !pop;
  assign push     = push_req && !drop;
  assign fin      = bus.output_finish && !stall;

  assign stream_nxt = (state_q == OW_STREAM) && !fin;
  assign free_nxt   = free - (PW+1)'(push) + (PW+1)'(pop);

  smem_line_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (LINE_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .push_i  (push),
    .data_i  (bus.output_data),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .free_o  (free)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= OW_IDLE;
      permit_q    <= 1'b0;
      stall_req_q <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      base_q      <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
    end else begin
      done_q <= 1'b0;
      // Looks one cycle ahead so the request lines up with occupancy.
      stall_req_q <= stream_nxt &&
                     (free_nxt <= (PW+1)'(STALL_SLACK));
      if (drop) ovf_q <= 1'b1;
      if (pop) begin
        idx_q <= idx_q + 1'b1;
        if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
        if (cnt_q >= CNT_MAX - CNT_W'(1)) ovf_q <= 1'b1;
      end
      unique case (state_q)
        OW_IDLE: begin
          // done_q blocks a re-grant in the batch_done cycle.
          if (enable && bus.output_request && !done_q) begin
            state_q  <= OW_STREAM;
            permit_q <= 1'b1;
            base_q   <= out_base;
            idx_q    <= '0;
            cnt_q    <= '0;
          end
        end
        OW_STREAM: begin
          if (fin) begin
            state_q  <= OW_DRAIN;
            permit_q <= 1'b0;
          end
        end
        OW_DRAIN: begin
          if (empty) state_q <= OW_TRAILER;
        end
        OW_TRAILER: begin
          if (bus.wr_ready) begin
            state_q <= OW_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= OW_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.wr_data = '0;
    if (state_q == OW_TRAILER)
      bus.wr_data = trailer_line(64'(cnt_q));
    else if (head_vld)
      bus.wr_data = head;
  end

  assign bus.wr_valid      = head_vld ||
                             (state_q == OW_TRAILER);
  assign bus.wr_addr       = base_q + idx_q;
  assign bus.output_permit = permit_q;
  assign stall_req         = stall_req_q;
  assign batch_done        = done_q;
  assign line_count        = cnt_q;
  assign overflow_err      = ovf_q;

endmodule

// File: tb/tb_smem_output_writer.sv
// Directed bench for smem_output_writer with a write scoreboard.
// Expected lines/addresses are built by the bench from each test's base.
module tb_smem_output_writer;
  import smem_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic [31:0] out_base;
  logic        stall;
  logic        stall_man;
  logic        tie_stall;
  logic        stall_req;
  logic        batch_done;
  logic [15:0] line_count;
  logic        overflow_err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0]  got_a[$];
  logic [511:0] got_d[$];
  logic [31:0]  exp_a[$];
  logic [511:0] exp_d[$];

  smem_output_writer_if #(.ADDR_W(32)) bus ();

  smem_output_writer #(
    .FIFO_DEPTH  (16),
    .STALL_SLACK (4),
    .ADDR_W      (32),
    .CNT_W       (16)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .out_base     (out_base),
    .stall        (stall),
    .stall_req    (stall_req),
    .bus          (bus),
    .batch_done   (batch_done),
    .line_count   (line_count),
    .overflow_err (overflow_err)
  );

  assign stall = tie_stall ? stall_req : stall_man;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset_n && bus.wr_valid && bus.wr_ready) begin
      got_a.push_back(bus.wr_addr);
      got_d.push_back(bus.wr_data);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [511:0] got,
                     input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] mk(input int t, input int k);
    logic [511:0] v;
    for (int w = 0; w < 16; w++)
      v[w*32 +: 32] = {8'(w), 8'(t), 16'(k)};
    return v;
  endfunction

  task automatic expect_wr(input logic [31:0] a,
                           input logic [511:0] d);
    exp_a.push_back(a);
    exp_d.push_back(d);
  endtask

  task automatic sb_check(input string tag);
    chk({tag, "_n"}, 512'(got_a.size()), 512'(exp_a.size()));
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
      chk($sformatf("%s_a%0d", tag, i), 512'(got_a[i]), 512'(exp_a[i]));
      chk($sformatf("%s_d%0d", tag, i), got_d[i], exp_d[i]);
    end
    got_a.delete(); got_d.delete();
    exp_a.delete(); exp_d.delete();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_permit"}, 512'(bus.output_permit), 512'(0));
    chk({tag, "_sreq"},   512'(stall_req), 512'(0));
    chk({tag, "_wvld"},   512'(bus.wr_valid), 512'(0));
    chk({tag, "_waddr"},  512'(bus.wr_addr), 512'(0));
    chk({tag, "_wdata"},  bus.wr_data, 512'(0));
    chk({tag, "_done"},   512'(batch_done), 512'(0));
    chk({tag, "_cnt"},    512'(line_count), 512'(0));
    chk({tag, "_ovf"},    512'(overflow_err), 512'(0));
  endtask

  task automatic start_batch(input string tag, input logic [31:0] base);
    bit seen;
    int lat;
    seen = 0;
    lat = 0;
    enable = 1'b1;
    out_base = base;
    bus.output_request = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.output_permit) begin
        seen = 1;
        lat = i;
        break;
      end
    end
    bus.output_request = 1'b0;
    chk({tag, "_permit"}, 512'(seen), 512'(1));
    chk({tag, "_plat"}, 512'(lat), 512'(0));
    chk({tag, "_cnt0"}, 512'(line_count), 512'(0));
  endtask

  // Holds the line until a cycle whose stall is low.
  task automatic send_line(input logic [511:0] d);
    bit s;
    bit ok;
    ok = 0;
    bus.output_valid = 1'b1;
    bus.output_data = d;
    for (int i = 0; i < 200; i++) begin
      s = stall;
      @(negedge clk);
      if (!s) begin
        ok = 1;
        break;
      end
    end
    bus.output_valid = 1'b0;
    if (!ok) chk("send_to", 512'(0), 512'(1));
  endtask

  task automatic send_finish();
    bus.output_finish = 1'b1;
    @(negedge clk);
    bus.output_finish = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (batch_done) begin
        seen = 1;
        break;
      end
    end
    chk({tag, "_done"}, 512'(seen), 512'(1));
    @(negedge clk);
    chk({tag, "_pulse"}, 512'(batch_done), 512'(0));
  endtask

  initial begin
    reset_n = 1'b0;
    enable = 1'b0;
    out_base = '0;
    stall_man = 1'b0;
    tie_stall = 1'b0;
    bus.output_request = 1'b0;
    bus.output_data = '0;
    bus.output_valid = 1'b0;
    bus.output_finish = 1'b0;
    bus.wr_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    reset_n = 1'b1;
    @(negedge clk);

    // Basic batch
    bus.wr_ready = 1'b1;
    start_batch("basic", 32'h1000);
    for (int k = 0; k < 5; k++) begin
      send_line(mk(1, k));
      expect_wr(32'h1000 + 32'(k), mk(1, k));
    end
    send_finish();
    expect_wr(32'h1005, 512'(5));
    wait_done("basic");
    chk("basic_cnt", 512'(line_count), 512'(5));
    sb_check("basic");

    // Backpressure with stall fed back from stall_req
    tie_stall = 1'b1;
    bus.wr_ready = 1'b0;
    start_batch("bp", 32'h2000);
    fork
      begin
        for (int k = 0; k < 20; k++) begin
          send_line(mk(2, k));
          expect_wr(32'h2000 + 32'(k), mk(2, k));
          if (k == 10) chk("bp_sreq11", 512'(stall_req), 512'(0));
          if (k == 11) chk("bp_sreq12", 512'(stall_req), 512'(1));
        end
      end
      begin
        repeat (20) @(negedge clk);
        bus.wr_ready = 1'b1;
      end
    join
    send_finish();
    expect_wr(32'h2014, 512'(20));
    wait_done("bp");
    chk("bp_ovf", 512'(overflow_err), 512'(0));
    chk("bp_cnt", 512'(line_count), 512'(20));
    sb_check("bp");
    tie_stall = 1'b0;

    // Stall qualification: one push across 3 stalled cycles
    start_batch("sq", 32'h3000);
    bus.output_valid = 1'b1;
    bus.output_data = mk(3, 0);
    stall_man = 1'b1;
    repeat (3) @(negedge clk);
    stall_man = 1'b0;
    @(negedge clk);
    bus.output_valid = 1'b0;
    expect_wr(32'h3000, mk(3, 0));
    send_finish();
    expect_wr(32'h3001, 512'(1));
    wait_done("sq");
    chk("sq_cnt", 512'(line_count), 512'(1));
    sb_check("sq");

    // Finish coincident with the last valid line
    start_batch("fc", 32'h4000);
    for (int k = 0; k < 2; k++) begin
      send_line(mk(4, k));
      expect_wr(32'h4000 + 32'(k), mk(4, k));
    end
    bus.output_valid = 1'b1;
    bus.output_data = mk(4, 2);
    bus.output_finish = 1'b1;
    @(negedge clk);
    bus.output_valid = 1'b0;
    bus.output_finish = 1'b0;
    expect_wr(32'h4002, mk(4, 2));
    expect_wr(32'h4003, 512'(3));
    wait_done("fc");
    chk("fc_cnt", 512'(line_count), 512'(3));
    sb_check("fc");

    // Forced overflow: 17 pushes, no drain
    bus.wr_ready = 1'b0;
    start_batch("of", 32'h5000);
    for (int k = 0; k < 17; k++) begin
      send_line(mk(5, k));
      if (k < 16) expect_wr(32'h5000 + 32'(k), mk(5, k));
    end
    chk("of_ovf", 512'(overflow_err), 512'(1));
    chk("of_hold_v", 512'(bus.wr_valid), 512'(1));
    chk("of_hold_a", 512'(bus.wr_addr), 512'(32'h5000));
    chk("of_hold_d", bus.wr_data, mk(5, 0));
    send_finish();
    bus.wr_ready = 1'b1;
    expect_wr(32'h5010, 512'(16));
    wait_done("of");
    chk("of_cnt", 512'(line_count), 512'(16));
    chk("of_sticky", 512'(overflow_err), 512'(1));
    sb_check("of");

    // Reset mid-DRAIN
    bus.wr_ready = 1'b0;
    start_batch("rd", 32'h6000);
    for (int k = 0; k < 3; k++) send_line(mk(6, k));
    send_finish();
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 chk_reset_vals("rd_rst");
    got_a.delete(); got_d.delete();
    @(negedge clk);
    reset_n = 1'b1;
    bus.wr_ready = 1'b1;
    @(negedge clk);
    start_batch("rn", 32'h7000);
    for (int k = 0; k < 2; k++) begin
      send_line(mk(7, k));
      expect_wr(32'h7000 + 32'(k), mk(7, k));
    end
    send_finish();
    expect_wr(32'h7002, 512'(2));
    wait_done("rn");
    chk("rn_cnt", 512'(line_count), 512'(2));
    sb_check("rn");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/smem_output_writer.md
# smem_output_writer

Downstream of the curr/mem result RAM stage, this block collects the 512-bit result lines that stage emits and writes them to host memory. It grants `output_permit` once a batch is ready and buffers incoming lines in a small FIFO. It throttles the SMEM pipeline through `stall_req` and streams the lines to the host write channel at consecutive cache-line addresses. When the batch is drained it appends a trailer line holding the line count, then pulses `batch_done`.

## Interface
- `FIFO_DEPTH`, 16: line buffer entries (power of two, ≥8).
- `STALL_SLACK`, 4: free entries kept in reserve for in-flight upstream lines (upstream output latency is 3 cycles).
- `ADDR_W`, 32: host cache-line address width.
- `CNT_W`, 16: line counter width.

Ports:
- `clk` in 1: the single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `enable` in 1: host arm; a batch is granted only while high.
- `out_base` in ADDR_W: cache-line base address, sampled on grant.
- `stall` in 1: global pipeline stall. Lines are ignored while it is high.
- `stall_req` out 1: request to assert the global stall.
- `output_request` in 1: upstream has a complete batch.
- `output_permit` out 1: upstream may stream.
- `output_data` in 512: result line.
- `output_valid` in 1: line valid, qualified by `!stall`.
- `output_finish` in 1: upstream has emitted its last line, qualified by `!stall`.
- `wr_valid` out 1: host write request.
- `wr_ready` in 1: host accepts the write.
- `wr_addr` out ADDR_W: cache-line address.
- `wr_data` out 512: line payload.
- `batch_done` out 1: one-cycle pulse when the trailer write is accepted.
- `line_count` out CNT_W: data lines written in the current or last batch.
- `overflow_err` out 1: sticky error flag, cleared only by reset.

## Operation
States:
- **IDLE**: `output_permit`=0. Moves to STREAM when `enable && output_request`. On that transition:
  - latch `out_base`;
  - clear `line_count` and `wr_idx`.
- **STREAM**: `output_permit`=1.
  - Push on `output_valid && !stall`.
  - On `output_finish && !stall`, move to DRAIN. A valid line arriving in the same cycle is still pushed.
- **DRAIN**: `output_permit`=0. When the FIFO is empty and no write is pending, move to TRAILER.
- **TRAILER**: present `wr_data` = {496'b0, line_count} at `wr_addr` = base + `wr_idx`. When `wr_ready` is seen, pulse `batch_done` and return to IDLE.

FIFO and write channel:
- The FIFO head drives `wr_valid`/`wr_data` in STREAM and DRAIN.
- A pop happens on `wr_valid && wr_ready`.
- Each pop increments `wr_idx` and `line_count`.
- `wr_addr` = base + `wr_idx`, computed modulo 2^ADDR_W (wraps silently).
- Simultaneous push and pop leaves the FIFO occupancy unchanged.
- `wr_valid`, `wr_addr` and `wr_data` must stay stable until `wr_ready` is seen.

Throttling and errors:
- `stall_req` = STREAM && (free entries ≤ STALL_SLACK).
- A push when the FIFO is full drops the line and sets `overflow_err`.
- `line_count` reaching 2^CNT_W−1 saturates it and sets `overflow_err`.
- Empty FIFO: `wr_valid`=0. There is never a pop from empty.
- `enable` deasserted mid-batch has no effect; the batch completes.
- `output_request` still high when the block returns to IDLE starts a new batch only from the cycle after `batch_done`.

## Timing
- Reset values (asynchronous, all outputs):
  - state IDLE;
  - `output_permit`=0, `stall_req`=0, `wr_valid`=0;
  - `wr_addr`=0, `wr_data`=0;
  - `batch_done`=0, `line_count`=0, `overflow_err`=0;
  - FIFO pointers 0.
- Reset asserted mid-batch discards all buffered data and issues no trailer.
- `output_permit` rises 1 cycle after `output_request && enable` is sampled in IDLE.
- Push-to-write latency: a line pushed at edge N can appear on `wr_valid` at edge N+1. The FIFO is registered; there is no combinational path from `output_data` to `wr_data`.
- `stall_req` is registered, so `STALL_SLACK` must cover its 1 cycle plus the 3 upstream cycles.
- The trailer is presented no earlier than 1 cycle after the last data pop.
- `batch_done` is high for exactly 1 cycle.

## Structure
- Shared package `smem_pkg`: line width 512, the `OW_IDLE`/`OW_STREAM`/`OW_DRAIN`/`OW_TRAILER` state encoding, and the trailer format constant.
- One sub-module, `smem_line_fifo`: synchronous FIFO with full, empty and free-count outputs, parameterised on depth and width.
- The FSM, counters and address generation live in the top module.

## Test plan
- **Basic batch:** request with `out_base`=0x1000, 5 valid lines, finish, `wr_ready`=1. Expect writes at 0x1000–0x1004 with matching data, trailer at 0x1005 with count 5, then `batch_done`.
- **Backpressure:** `wr_ready`=0 for 20 cycles while upstream streams. Expect `stall_req` to assert at 12 occupied entries, `overflow_err` to stay 0, and all lines delivered in order.
- **Stall qualification:** `output_valid`=1 held through 3 `stall`=1 cycles. Expect exactly 1 push.
- **Finish coincident with valid:** last line arrives in the same cycle as `output_finish`. Expect it written before the trailer, with count including it.
- **Forced overflow:** `STALL_SLACK` ignored by the bench, 17 pushes with `wr_ready`=0. Expect `overflow_err`=1 and the 17th line absent.
- **Reset mid-DRAIN:** Expect all outputs at reset values immediately; a new request afterwards restarts from the new base with count 0.
